// File: rtl/ip_write_sink_if.sv
// ip_write_sink_if: MEM/WB write input and IP-core output handshake of the write sink
interface ip_write_sink_if;
  logic IP_write_in;
  logic [31:0] data_in;
  logic dataena_out;
  logic [31:0] ip_data;
  logic ip_valid;
  logic ip_ready;
  logic ip_first;
  logic ip_last;
  logic [7:0] ip_opcode;
  logic busy;
  modport slave (
    input IP_write_in, data_in, ip_ready,
    output dataena_out, ip_data, ip_valid, ip_first, ip_last, ip_opcode, busy
  );
  modport master (
    output IP_write_in, data_in, ip_ready,
    input dataena_out, ip_data, ip_valid, ip_first, ip_last, ip_opcode, busy
  );
endinterface

// File: rtl/ip_write_sink.sv
// ip_write_sink: buffers MEM/WB IP writes in a FIFO, frames them and holds the latch when full
module ip_write_sink #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  ip_write_sink_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] HDR = 1'b0;
  localparam logic [0:0] PAY = 1'b1;
  logic [33:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [0:0] state;
  logic [7:0] remaining, opcode_q, opcode;
  logic full, valid, push, pop, tag_first, tag_last;
  logic [33:0] head;
  assign full = count == CNT_W'(DEPTH);
  assign valid = count != '0;
  assign push = bus.IP_write_in && !full;
  assign pop = valid && bus.ip_ready;
  assign tag_first = state == HDR;
  assign tag_last = tag_first ? bus.data_in[7:0] == 8'd0 : remaining == 8'd1;
  assign head = valid ? mem[rd_ptr] : '0;
  assign opcode = (valid && head[1]) ? head[33:26] : opcode_q;
  assign bus.dataena_out = full;
  assign bus.ip_valid = valid;
  assign bus.ip_data = head[33:2];
  assign bus.ip_first = head[1];
  assign bus.ip_last = head[0];
  assign bus.ip_opcode = opcode;
  assign bus.busy = valid || state == PAY;
  // pointers, occupancy, receive framing and the held opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= HDR;
      remaining <= '0;
      opcode_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) state <= tag_last ? HDR : PAY;
      if (push) remaining <= tag_first ? bus.data_in[7:0] : remaining - 8'd1;
      opcode_q <= opcode;
    end
  end
  // FIFO storage: word plus first/last tags
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.data_in, tag_first, tag_last};
  end
endmodule

// File: tb/tb_ip_write_sink.sv
// tb_ip_write_sink: directed self-checking bench for ip_write_sink
module tb_ip_write_sink;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  ip_write_sink_if bus ();
  ip_write_sink dut (.clk(clk), .rst(rst), .bus(bus));
  logic [42:0] obs;
  assign obs = {bus.ip_valid, bus.ip_first, bus.ip_last, bus.ip_opcode, bus.ip_data};
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [44:0] all;
    bus.IP_write_in = 1'b0;
    bus.data_in = '0;
    bus.ip_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    all = {obs, bus.dataena_out, bus.busy};
    n_cmp++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", all);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      all = {obs, bus.dataena_out, bus.busy};
      n_cmp++;
      if (all !== '0) begin
        n_err++;
        $display("FAIL idle_outputs cycle %0d got %h want 0", i, all);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] w [3];
    w = '{32'hA5000002, 32'h11111111, 32'h22222222};
    bus.ip_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.IP_write_in = 1'b1;
      bus.data_in = w[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== {1'b1, i == 0, i == 2, 8'hA5, w[i]}) begin
        n_err++;
        $display("FAIL single_word%0d got %h want %h", i, obs, {1'b1, i == 0, i == 2, 8'hA5, w[i]});
      end
    end
    bus.IP_write_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ip_valid, bus.busy, bus.ip_opcode} !== {1'b0, 1'b0, 8'hA5}) begin
      n_err++;
      $display("FAIL single_end got v=%b busy=%b op=%h want v=0 busy=0 op=a5", bus.ip_valid, bus.busy, bus.ip_opcode);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] w [3];
    logic [7:0] op [3];
    w = '{32'h3C000000, 32'h4D000001, 32'h00000005};
    op = '{8'h3C, 8'h4D, 8'h4D};
    bus.ip_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.IP_write_in = 1'b1;
      bus.data_in = w[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== {1'b1, i != 2, i != 1, op[i], w[i]}) begin
        n_err++;
        $display("FAIL zero_len_word%0d got %h want %h", i, obs, {1'b1, i != 2, i != 1, op[i], w[i]});
      end
    end
    bus.IP_write_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ip_valid, bus.busy} !== 2'b00) begin
      n_err++;
      $display("FAIL zero_len_end got v=%b busy=%b want 00", bus.ip_valid, bus.busy);
    end
  endtask

  task automatic test_full();
    logic [31:0] w [6];
    w[0] = 32'h77000005;
    for (int i = 1; i < 6; i++) w[i] = 32'hB0000000 + 32'(i);
    bus.ip_ready = 1'b0;
    bus.IP_write_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = w[i];
      @(negedge clk);
      n_cmp++;
      if (bus.dataena_out !== (i == 3)) begin
        n_err++;
        $display("FAIL full_fill%0d dataena got %b want %b", i, bus.dataena_out, i == 3);
      end
    end
    bus.data_in = w[4];
    @(negedge clk);
    n_cmp++;
    if ({bus.dataena_out, obs} !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h77, w[0]}) begin
      n_err++;
      $display("FAIL full_hold got %h want %h", {bus.dataena_out, obs}, {1'b1, 1'b1, 1'b1, 1'b0, 8'h77, w[0]});
    end
    bus.ip_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.dataena_out, obs} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h77, w[1]}) begin
      n_err++;
      $display("FAIL full_one_pop got %h want %h", {bus.dataena_out, obs}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h77, w[1]});
    end
    bus.ip_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.dataena_out, obs} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h77, w[1]}) begin
      n_err++;
      $display("FAIL full_refill got %h want %h", {bus.dataena_out, obs}, {1'b1, 1'b1, 1'b0, 1'b0, 8'h77, w[1]});
    end
    bus.data_in = w[5];
    bus.ip_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) bus.IP_write_in = 1'b0;
      n_cmp++;
      if (obs !== {1'b1, 1'b0, i == 5, 8'h77, w[i]}) begin
        n_err++;
        $display("FAIL full_drain%0d got %h want %h", i, obs, {1'b1, 1'b0, i == 5, 8'h77, w[i]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.ip_valid, bus.busy, bus.dataena_out} !== 3'b000) begin
      n_err++;
      $display("FAIL full_end got %b want 000", {bus.ip_valid, bus.busy, bus.dataena_out});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s [10];
    s[0] = 32'h12000009;
    for (int i = 1; i < 10; i++) s[i] = 32'hC0000000 + 32'(i);
    bus.ip_ready = 1'b0;
    bus.IP_write_in = 1'b1;
    bus.data_in = s[0];
    @(negedge clk);
    bus.data_in = s[1];
    @(negedge clk);
    bus.ip_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.IP_write_in = k < 8;
      if (k < 8) bus.data_in = s[k + 2];
      n_cmp++;
      if ({bus.dataena_out, obs} !== {1'b0, 1'b1, k == 0, k == 9, 8'h12, s[k]}) begin
        n_err++;
        $display("FAIL stream_word%0d got %h want %h", k, {bus.dataena_out, obs}, {1'b0, 1'b1, k == 0, k == 9, 8'h12, s[k]});
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({bus.ip_valid, bus.busy} !== 2'b00) begin
      n_err++;
      $display("FAIL stream_end got v=%b busy=%b want 00", bus.ip_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w [3];
    logic [45:0] all;
    w = '{32'h66000005, 32'hD0000001, 32'hD0000002};
    bus.ip_ready = 1'b0;
    bus.IP_write_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = w[i];
      @(negedge clk);
    end
    n_cmp++;
    if ({bus.busy, obs} !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h66, w[0]}) begin
      n_err++;
      $display("FAIL mid_before got %h want %h", {bus.busy, obs}, {1'b1, 1'b1, 1'b1, 1'b0, 8'h66, w[0]});
    end
    bus.IP_write_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    all = {bus.busy, bus.dataena_out, bus.ip_ready, obs};
    n_cmp++;
    if (all !== '0) begin
      n_err++;
      $display("FAIL mid_reset got %h want 0", all);
    end
    bus.IP_write_in = 1'b1;
    bus.data_in = 32'h99000000;
    @(negedge clk);
    bus.IP_write_in = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b1, 8'h99, 32'h99000000}) begin
      n_err++;
      $display("FAIL mid_next_header got %h want %h", obs, {1'b1, 1'b1, 1'b1, 8'h99, 32'h99000000});
    end
    bus.ip_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.ip_valid, bus.busy} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_end got v=%b busy=%b want 00", bus.ip_valid, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_zero_len();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ip_write_sink.md
Name: ip_write_sink

Overview:
- Receiving end of the writeback-stage IP write interface. Consumes the IP_write_out / data_out pair produced by the MEM/WB pipeline latch.
- Buffers words in a small FIFO, parses them into framed commands (one header word plus N payload words), and presents them to the IP core over a valid/ready handshake.
- Drives the hold signal back into the MEM/WB latch's dataena input, so the pipeline freezes while the sink is full.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- CNT_W, 3, width of the occupancy counter; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- IP_write_in  input  1  word-valid from the MEM/WB latch (its IP_write_out).
- data_in  input  32  word from the MEM/WB latch (its data_out).
- dataena_out  output  1  hold request to the MEM/WB latch dataena; 1 = hold.
- ip_data  output  32  FIFO head word.
- ip_valid  output  1  ip_data is valid.
- ip_ready  input  1  IP core accepts the head word this cycle.
- ip_first  output  1  head word is a frame header.
- ip_last  output  1  head word is the final word of its frame.
- ip_opcode  output  8  opcode of the frame currently at the head, header bits [31:24]; held for the whole frame.
- busy  output  1  FIFO not empty, or a frame is partially received.

Behaviour:
- Reset: when rst=1 at a clock edge, the following are cleared:
  - FIFO pointers, count, and the receive FSM (forced to HDR).
  - Outputs: ip_valid=0, ip_first=0, ip_last=0, ip_opcode=0, ip_data=0, dataena_out=0, busy=0.
  - rst takes priority over every other event, including mid-frame and with the FIFO full. Partial frames are discarded.
- Accept rule: a word is accepted at an edge when IP_write_in=1 and dataena_out=0.
  - dataena_out is combinational: it equals 1 exactly when count == DEPTH.
  - While dataena_out=1 the latch holds its word on IP_write_in/data_in. That held word is not accepted until space frees, and is accepted exactly once.
- Pop rule: the head word is popped at an edge when ip_valid=1 and ip_ready=1.
- ip_valid = (count != 0).
- ip_data, ip_first and ip_last are taken from the FIFO head entry. Each entry stores 34 bits: data, first, last.
- Simultaneous push and pop with count == DEPTH:
  - dataena_out is already 1, so no push occurs; the pop proceeds and the count drops to DEPTH-1.
  - The held word is accepted on the next edge. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, both pointers advance.
- Empty FIFO: no fall-through. A word accepted at edge k is visible with ip_valid=1 after edge k. Minimum latency is 1 cycle.
- Pointers wrap modulo DEPTH.
- Receive FSM (advances only on accepted words):
  - HDR: the accepted word is a header, tagged first=1.
    - If len = bits[7:0] is 0: tag last=1 and stay in HDR.
    - Otherwise: load remaining = len, tag last=0, go to PAY.
  - PAY: the accepted word is payload, tagged first=0, and remaining is decremented.
    - If remaining was 1: tag last=1 and go to HDR.
    - Otherwise: tag last=0 and stay in PAY.
  - Header bits [23:8] are passed through unmodified.
- ip_opcode is updated from ip_data[31:24] whenever a word with first=1 reaches the head with ip_valid=1. It holds that value until the next header reaches the head.
- busy = (count != 0) || (FSM == PAY).
- Back-to-back frames need no idle cycle between them.
- IP_write_in=0 cycles inside a frame are legal gaps; the FSM holds its state.

Test Plan:
- Reset then idle:
  - After rst=1 for 2 cycles: all outputs are 0.
  - With IP_write_in=0 for 10 cycles: outputs stay 0 and busy=0.
- Single frame, ip_ready=1:
  - Stimulus: push header 0xA5000002, then 0x11111111, then 0x22222222 on consecutive cycles.
  - Required: 3 words out in order, one per cycle, starting 1 cycle after the first push.
  - Flags: ip_first=1 on the header, ip_last=1 on 0x22222222 only; ip_opcode=0xA5.
- Zero-length frame:
  - Stimulus: push header 0x3C000000, then header 0x4D000001 and payload 0x5.
  - Required: the first word has ip_first=1 and ip_last=1. The second frame is parsed correctly, with ip_last=1 on payload 0x5.
- Full/backpressure:
  - Stimulus: ip_ready=0, push 6 words of one frame (DEPTH=4).
  - Required: dataena_out=1 after the 4th accept. Words 5 and 6 are held at the input.
  - Then raise ip_ready for one cycle: exactly one pop occurs, then word 5 is accepted once with no duplication. The order is preserved.
- Simultaneous push/pop at partial fill:
  - Stimulus: count=2, continuous push with ip_ready=1 for 8 cycles.
  - Required: count stays 2, pointers wrap correctly, and no data is lost.
- Reset mid-frame:
  - Stimulus: header with len=5, 2 payload words pushed, then rst=1 for 1 cycle.
  - Required: FIFO empty, busy=0, FSM in HDR. The next pushed word is treated as a header (ip_first=1).
